dsp_mac_group: RTL and testbench
================================

# dsp_mac_group

Parametrised multi-beat dot-product engine for the DDR bandwidth/compute test path. Each accepted beat multiplies N_MUL signed fixed-point weight/feature-map pairs at full precision and reduces them through a pipelined adder tree. Results accumulate across beats until a beat marked last, after which one rounded, saturated DW-bit result is emitted. It replaces the fixed 3-lane, single-beat, per-product-truncating DSP group. Multipliers are inferred so that they map onto DSP48E1 slices.

## Interface
- N_MUL, 4: number of multiplier lanes (≥1).
- DW, 16: signed width of each weight, feature and result element.
- FRAC, 9: fractional bits; the result is the accumulator arithmetically shifted right by FRAC (0 ≤ FRAC < 2*DW).
- ACCW, 40: accumulator/tree width (≥ 2*DW + clog2(N_MUL)).
- CNTW, 16: beat-counter width.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  beat present this cycle.
- in_last  in  1  final beat of the current dot product (qualified by in_valid).
- wei  in  DW*N_MUL  signed weights; lane j is at [j*DW +: DW].
- fm  in  DW*N_MUL  signed feature-map values, same lane packing as wei.
- out_valid  out  1  one-cycle pulse when a result is ready.
- out_data  out  DW  signed rounded, saturated result.
- out_sat  out  1  out_data was clipped (valid with out_valid).
- out_cnt  out  CNTW  number of beats accumulated; saturates at all-ones.

## Operation
- No backpressure. Every cycle with in_valid=1 is accepted, and the downstream block must accept every out_valid pulse.
- Pipeline, with T = clog2(N_MUL) and T=0 when N_MUL=1:
  - S0: register wei, fm, valid and last.
  - S1: register the 2*DW-bit signed product of each lane; no truncation.
  - S2..S1+T: pairwise adder-tree levels, each registered, sign-extended to ACCW. An odd leftover lane passes through its level.
  - ACC stage:
    - If the beat is valid and this is the first beat of a dot product: acc = tree sum, cnt = 1.
    - Otherwise, if valid: acc += tree sum, cnt += 1 (saturating at all-ones).
    - Invalid bubbles leave acc and cnt untouched.
    - A valid last beat marks the next beat as first.
  - OUT stage, when the last beat leaves ACC:
    - r = (acc_final + (FRAC>0 ? 2^(FRAC-1) : 0)) >>> FRAC, i.e. round half up toward +inf.
    - If r > 2^(DW-1)-1, out_data = max and out_sat=1. If r < -2^(DW-1), out_data = min and out_sat=1.
    - Otherwise out_data = r and out_sat=0.
    - out_cnt = final count; out_valid=1 for one cycle.
- ACCW overflow wraps two's-complement and is not flagged.
- Per-beat stage valids are the only sequencing; no other state machine. The accumulator state is FIRST (awaiting first beat) or ACCUM (mid dot product).
- Reset (rstn=0 at a clk edge) clears:
  - all pipeline valids and the acc/cnt registers;
  - the accumulator state to FIRST.
  - out_valid=0, out_data=0, out_sat=0, out_cnt=0.
  - Any partial accumulation is discarded.
- Simultaneous events:
  - A last beat followed immediately by a new beat needs no gap. The new beat starts fresh, and the two results appear on consecutive cycles.
  - in_last with in_valid=0 is ignored.
  - A single beat with in_last=1 is a complete one-beat dot product.

## Timing
- Latency: a beat sampled at edge n with in_valid=in_last=1 produces out_valid high after edge n+3+T+1. That is LAT = 4+T edges; for N_MUL=4, LAT = 6.
- Throughput: one beat per cycle, sustained indefinitely.
- Outputs are registered. out_data, out_sat and out_cnt hold their last value while out_valid=0.
- The first input accepted after rstn returns to 1 is the cycle rstn is sampled high.

## Test plan
All scenarios use N_MUL=4, DW=16, FRAC=9, ACCW=40.
- **Single beat:** wei all 512, fm = {1024, 2048, -512, 512}, last=1 -> out_data=3072, out_sat=0, out_cnt=1; out_valid exactly 6 edges later, one cycle wide.
- **Accumulation with bubble:** three beats with wei=fm=512 on all lanes, one idle cycle between beats 2 and 3, last on beat 3 -> one pulse with out_data=6144, out_cnt=3.
- **Saturation:**
  - wei=fm=32767 on all lanes, single beat -> out_data=32767, out_sat=1.
  - wei=-32768, fm=32767 on all lanes -> out_data=-32768, out_sat=1.
- **Rounding:** lane0 only, others 0.
  - wei=1, fm=256 -> 1.
  - wei=1, fm=255 -> 0.
  - wei=-1, fm=256 -> 0.
  - wei=-1, fm=257 -> -1.
- **Back-to-back:** beat A (wei=fm=512 all lanes, last) then next cycle beat B (wei=512, fm=1024 all lanes, last) -> consecutive pulses 2048 then 4096, each with out_cnt=1.
- **Reset mid-stream:** two non-last beats (2048 each), rstn low one cycle, then one last beat with sum 2048 -> single result 2048, out_cnt=1. All outputs are 0 during and after reset until that result, with no spurious out_valid.

Source files
------------

// File: rtl/dsp_mac_group_if.sv
// Beat-in / result-out bundle for the multi-beat dot-product engine.
// Latency: none (wires only).
// Backpressure: none; the master must accept every out_valid pulse.
interface dsp_mac_group_if #(
  parameter int N_MUL = 4,
  parameter int DW    = 16,
  parameter int CNTW  = 16
) ();
  logic                  in_valid;
  logic                  in_last;
  logic [DW*N_MUL-1:0]   wei;
  logic [DW*N_MUL-1:0]   fm;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic                  out_sat;
  logic [CNTW-1:0]       out_cnt;

  modport master (
    output in_valid, in_last, wei, fm,
    input  out_valid, out_data, out_sat, out_cnt
  );

  modport slave (
    input  in_valid, in_last, wei, fm,
    output out_valid, out_data, out_sat, out_cnt
  );
endinterface

// File: rtl/dsp_mac_group.sv
// Multi-beat signed dot product: N_MUL full-precision products per beat, adder tree, accumulate to last, round+saturate.
// Latency: 4 + clog2(N_MUL) edges from the sampling edge of the last beat to out_valid.
// Backpressure: none; one beat per cycle accepted, every result pulse must be taken.
module dsp_mac_group #(
  parameter int N_MUL = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 9,
  parameter int ACCW  = 40,
  parameter int CNTW  = 16
) (
  input logic            clk,
  input logic            rstn,
  dsp_mac_group_if.slave bus
);

  localparam int T  = (N_MUL > 1) ? $clog2(N_MUL) : 0;
  // Tree storage is padded to 2*N_MUL zero entries so every pair index is in range;
  // an odd leftover lane is summed with a zero, which is a plain pass-through.
  localparam int NW = 2 * N_MUL;
  localparam logic signed [ACCW-1:0] HALF =
    (FRAC > 0) ? (ACCW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {FIRST, ACCUM} acc_st_t;

  logic signed [DW-1:0]   wei_q [N_MUL];
  logic signed [DW-1:0]   fm_q  [N_MUL];
  logic                   s0_vld_q, s0_lst_q;
  logic signed [ACCW-1:0] tree_q [T+1][NW];
  logic [T:0]             tv_q, tl_q;
  acc_st_t                st_q;
  logic signed [ACCW-1:0] acc_q;
  logic [CNTW-1:0]        cnt_q;
  logic                   fin_q;
  logic signed [ACCW-1:0] rnd_q;
  logic [CNTW-1:0]        rnd_cnt_q;
  logic                   rnd_vld_q;
  logic                   out_vld_q, out_sat_q;
  logic [DW-1:0]          out_data_q;
  logic [CNTW-1:0]        out_cnt_q;
  logic [DW-1:0]          out_data_d;
  logic                   out_sat_d;
  logic [ACCW-DW:0]       rnd_hi;

  // S0: capture the raw beat; last is only meaningful together with valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s0_vld_q <= 1'b0;
      s0_lst_q <= 1'b0;
    end else begin
      s0_vld_q <= bus.in_valid;
      s0_lst_q <= bus.in_valid & bus.in_last;
    end
    for (int j = 0; j < N_MUL; j++) begin
      wei_q[j] <= bus.wei[j*DW +: DW];
      fm_q[j]  <= bus.fm[j*DW +: DW];
    end
  end

  // S1 products (level 0) and registered pairwise adder-tree levels, with their valid/last shadow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tv_q <= '0;
      tl_q <= '0;
    end else begin
      tv_q[0] <= s0_vld_q;
      tl_q[0] <= s0_lst_q;
      for (int l = 1; l <= T; l++) begin
        tv_q[l] <= tv_q[l-1];
        tl_q[l] <= tl_q[l-1];
      end
    end
    for (int i = 0; i < N_MUL; i++)
      tree_q[0][i] <= ACCW'(wei_q[i]) * ACCW'(fm_q[i]);
    for (int i = N_MUL; i < NW; i++)
      tree_q[0][i] <= '0;
    for (int l = 1; l <= T; l++) begin
      for (int i = 0; i < N_MUL; i++)
        tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
      for (int i = N_MUL; i < NW; i++)
        tree_q[l][i] <= '0;
    end
  end

  // ACC: first beat loads, later beats add; a valid last beat re-arms FIRST and flags the result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q  <= FIRST;
      acc_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
    end else begin
      fin_q <= tv_q[T] & tl_q[T];
      if (tv_q[T]) begin
        if (st_q == FIRST) begin
          acc_q <= tree_q[T][0];
          cnt_q <= CNTW'(1);
        end else begin
          acc_q <= acc_q + tree_q[T][0];
          cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
        end
        st_q <= tl_q[T] ? FIRST : ACCUM;
      end
    end
  end

  // RND: round half up toward +inf, then drop the fractional bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rnd_vld_q <= 1'b0;
    end else begin
      rnd_vld_q <= fin_q;
    end
    if (fin_q) begin
      rnd_q     <= (acc_q + HALF) >>> FRAC;
      rnd_cnt_q <= cnt_q;
    end
  end

  // The rounded value fits DW bits exactly when all bits from DW-1 upward agree.
  assign rnd_hi = rnd_q[ACCW-1:DW-1];

  // Saturate to the signed DW range, direction taken from the accumulator sign.
  always_comb begin
    out_data_d = rnd_q[DW-1:0];
    out_sat_d  = 1'b0;
    if (!((&rnd_hi) | ~(|rnd_hi))) begin
      out_sat_d  = 1'b1;
      out_data_d = rnd_q[ACCW-1] ? DMIN : DMAX;
    end
  end

  // OUT: one-cycle valid pulse; data/sat/cnt hold between results.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      out_vld_q <= rnd_vld_q;
      if (rnd_vld_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
        out_cnt_q  <= rnd_cnt_q;
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_dsp_mac_group.sv
// Bench for dsp_mac_group: table vectors, hand sequences for multi-beat corners, random dot products vs a reference model.
// Latency: results expected LAT=6 edges after the sampling edge of the last beat.
// Backpressure: none; every pulse is matched against the expectation queue.
module tb_dsp_mac_group;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int FRAC = 9;
  localparam int ACCW = 40;
  localparam int CNTW = 16;
  localparam int LAT  = 6;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dsp_mac_group_if #(.N_MUL(N), .DW(DW), .CNTW(CNTW)) bus ();

  dsp_mac_group #(.N_MUL(N), .DW(DW), .FRAC(FRAC), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    int d;
    bit s;
    int c;
    int e;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [N*DW-1:0] w;
    logic [N*DW-1:0] f;
    int              d;
    bit              s;
  } vec_t;

  // Reference model state: running dot-product sum and beat count.
  longint m_acc;
  int     m_cnt;
  bit     m_first;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] L4(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic void ref_round(input longint acc, output int d, output bit s);
    longint r;
    r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > 32767) begin
      d = 32767; s = 1'b1;
    end else if (r < -32768) begin
      d = -32768; s = 1'b1;
    end else begin
      d = int'(r); s = 1'b0;
    end
  endfunction

  task automatic push(input int d, input bit s, input int c);
    exp_t e;
    e.d = d; e.s = s; e.c = c;
    e.e = edge_cnt + 1 + LAT;
    sbq.push_back(e);
  endtask

  task automatic apply(input logic [N*DW-1:0] w, input logic [N*DW-1:0] f,
                       input bit v, input bit l, input bit use_model);
    bus.wei = w;
    bus.fm = f;
    bus.in_valid = v;
    bus.in_last = l;
    if (v) begin
      longint dot = 0;
      for (int j = 0; j < N; j++)
        dot += longint'($signed(w[j*DW +: DW])) * longint'($signed(f[j*DW +: DW]));
      if (m_first) begin
        m_acc = dot; m_cnt = 1;
      end else begin
        m_acc += dot; m_cnt++;
      end
      m_first = l;
      if (l && use_model) begin
        int d;
        bit s;
        ref_round(m_acc, d, s);
        push(d, s, m_cnt);
      end
    end
  endtask

  task automatic drive(input logic [N*DW-1:0] w, input logic [N*DW-1:0] f,
                       input bit v, input bit l, input bit use_model);
    @(negedge clk);
    apply(w, f, v, l, use_model);
  endtask

  task automatic zchk(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, $signed(bus.out_data), 0);
    chk({tag, "_sat"}, bus.out_sat, 0);
    chk({tag, "_cnt"}, bus.out_cnt, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      if (sbq.size() == 0) break;
    end
    repeat (2) @(negedge clk);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_out_valid: got no pulse by edge %0d, expected data %0d at edge %0d", edge_cnt, e.d, e.e);
    end
  endtask

  function automatic logic [N*DW-1:0] rv(input bit big);
    logic [N*DW-1:0] v;
    int x;
    for (int j = 0; j < N; j++) begin
      if (big) begin
        v[j*DW +: DW] = 16'($urandom);
      end else begin
        x = $urandom_range(0, 511) - 256;
        v[j*DW +: DW] = x[15:0];
      end
    end
    return v;
  endfunction

  // Result monitor: every pulse must match the oldest expectation, including its arrival edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out_valid: got pulse at edge %0d, expected none", edge_cnt);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", $signed(bus.out_data), e.d);
        chk("out_sat", bus.out_sat, e.s);
        chk("out_cnt", bus.out_cnt, e.c);
        chk("latency_edge", edge_cnt, e.e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[8];
    logic [N*DW-1:0] a512, a1024;
    int nb;
    bit big;

    vt[0] = '{L4(512, 512, 512, 512), L4(1024, 2048, -512, 512), 3072, 1'b0};
    vt[1] = '{L4(32767, 32767, 32767, 32767), L4(32767, 32767, 32767, 32767), 32767, 1'b1};
    vt[2] = '{L4(-32768, -32768, -32768, -32768), L4(32767, 32767, 32767, 32767), -32768, 1'b1};
    vt[3] = '{L4(1, 0, 0, 0), L4(256, 0, 0, 0), 1, 1'b0};
    vt[4] = '{L4(1, 0, 0, 0), L4(255, 0, 0, 0), 0, 1'b0};
    vt[5] = '{L4(-1, 0, 0, 0), L4(256, 0, 0, 0), 0, 1'b0};
    vt[6] = '{L4(-1, 0, 0, 0), L4(257, 0, 0, 0), -1, 1'b0};
    vt[7] = '{L4(-512, -512, -512, -512), L4(1024, 1024, 1024, 1024), -4096, 1'b0};
    a512  = L4(512, 512, 512, 512);
    a1024 = L4(1024, 1024, 1024, 1024);

    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.wei = '0;
    bus.fm = '0;
    m_first = 1'b1;
    m_acc = 0;
    m_cnt = 0;
    repeat (3) @(negedge clk);
    zchk("reset");
    rstn = 1'b1;

    // Single-beat table, with occasional invalid cycles carrying a stray last.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].w, vt[i].f, 1'b1, 1'b1, 1'b0);
      push(vt[i].d, vt[i].s, 1);
      if (i % 2 == 1) drive(rv(1'b1), rv(1'b1), 1'b0, 1'b1, 1'b0);
    end
    drain();

    // Three beats with a bubble (last asserted without valid) before the final beat.
    drive(a512, a512, 1'b1, 1'b0, 1'b0);
    drive(a512, a512, 1'b1, 1'b0, 1'b0);
    drive(a512, a512, 1'b0, 1'b1, 1'b0);
    drive(a512, a512, 1'b1, 1'b1, 1'b0);
    push(6144, 1'b0, 3);
    drain();

    // Back-to-back one-beat products.
    drive(a512, a512, 1'b1, 1'b1, 1'b0);
    push(2048, 1'b0, 1);
    drive(a512, a1024, 1'b1, 1'b1, 1'b0);
    push(4096, 1'b0, 1);
    drain();

    // Reset in the middle of a dot product discards the partial sum.
    drive(a512, a512, 1'b1, 1'b0, 1'b0);
    drive(a512, a512, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    m_first = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    zchk("rst_hold");
    apply(a512, a512, 1'b1, 1'b1, 1'b0);
    push(2048, 1'b0, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      apply('0, '0, 1'b0, 1'b0, 1'b0);
      zchk($sformatf("post_rst%0d", k));
    end
    drain();

    // Random dot products of 1..6 beats, random bubbles, against the reference model.
    for (int t = 0; t < 40; t++) begin
      nb = $urandom_range(1, 6);
      big = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0)
          drive(rv(1'b1), rv(1'b1), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        drive(rv(big), rv(big), 1'b1, b == nb - 1, 1'b1);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
